// File: rtl/in_filter_pkg.sv
// Shared defaults and helpers for the in_filter input conditioning stage.
package in_filter_pkg;

    localparam int IN_FILTER_SYNC_STAGES = 2;
    localparam int IN_FILTER_LEN         = 4;
    localparam int IN_FILTER_CNT_W       = 8;

    // A filter length of 1 still needs a 1-bit counter to keep the compare well formed.
    function automatic int fc_width(input int filter_len);
        int w;
        w = $clog2(filter_len);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/in_filter_sync.sv
// Plain flop chain that brings the raw asynchronous level into the clk domain.
module sync_chain
    import in_filter_pkg::*;
#(
    parameter int SYNC_STAGES = IN_FILTER_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] r_sync;

    // Only r_sync[0] may go metastable; nothing sits between the stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d};
        end
    end

    assign q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/in_filter.sv
// Synchronizes and deglitches an async level, producing a clean level and rise/fall strobes.
// Define IN_FILTER_EDGE_CNT_EN to build the saturating edge counter with cnt_clr/edge_cnt.
module in_filter
    import in_filter_pkg::*;
#(
    parameter int SYNC_STAGES = IN_FILTER_SYNC_STAGES,
    parameter int FILTER_LEN  = IN_FILTER_LEN,
    parameter int CNT_W       = IN_FILTER_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
`ifdef IN_FILTER_EDGE_CNT_EN
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] edge_cnt,
`endif
    output logic             out,
    output logic             rise,
    output logic             fall
);

    localparam int FC_W = fc_width(FILTER_LEN);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILTER_LEN - 1);

    logic            w_s;
    logic            w_next_out;
    logic [FC_W-1:0] w_next_fc;
    logic [FC_W-1:0] r_fc;
    logic            r_out;
    logic            r_rise;
    logic            r_fall;

    sync_chain #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (in),
        .q  (w_s)
    );

    // out only follows s after FILTER_LEN consecutive cycles of disagreement.
    always_comb begin
        w_next_out = r_out;
        w_next_fc  = '0;
        if (w_s != r_out) begin
            if (r_fc == FC_LAST) begin
                w_next_out = w_s;
            end else begin
                w_next_fc = r_fc + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fc   <= '0;
            r_out  <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_fc   <= w_next_fc;
            r_out  <= w_next_out;
            r_rise <= w_next_out & ~r_out;
            r_fall <= ~w_next_out & r_out;
        end
    end

    assign out  = r_out;
    assign rise = r_rise;
    assign fall = r_fall;

`ifdef IN_FILTER_EDGE_CNT_EN
    logic [CNT_W-1:0] r_edge_cnt;

    // Clear takes priority, so an event in the clearing cycle is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_edge_cnt <= '0;
        end else if (cnt_clr) begin
            r_edge_cnt <= '0;
        end else if ((r_rise | r_fall) && (r_edge_cnt != '1)) begin
            r_edge_cnt <= r_edge_cnt + 1'b1;
        end
    end

    assign edge_cnt = r_edge_cnt;
`else
    // CNT_W only matters when the counter is built; keep it referenced here.
    if (CNT_W < 1) begin : g_cnt_w_unused
    end
`endif

endmodule

// File: tb/tb_in_filter.sv
// Directed bench for in_filter: default, CNT_W=2 and FILTER_LEN=1 instances with strobe scoreboards.
module tb_in_filter;

    logic clk = 1'b0;
    logic rst;
    logic in_a, in_sat, in_f1;
    logic out_a, rise_a, fall_a;
    logic out_sat, rise_sat, fall_sat;
    logic out_f1, rise_f1, fall_f1;
    int   edge_n = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    // Entry = {is_rise, edge number on which the strobe must appear}.
    logic [31:0] exp_q[$];
    logic [31:0] exp_f1_q[$];

`ifdef IN_FILTER_EDGE_CNT_EN
    logic       cnt_clr_a, cnt_clr_sat;
    logic [7:0] edge_cnt_a;
    logic [1:0] edge_cnt_sat;
    logic [7:0] edge_cnt_f1;
    logic [31:0] exp_sat_q[$];
    logic        sat_pend = 1'b0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    in_filter dut (
        .clk(clk), .rst(rst), .in(in_a),
`ifdef IN_FILTER_EDGE_CNT_EN
        .cnt_clr(cnt_clr_a), .edge_cnt(edge_cnt_a),
`endif
        .out(out_a), .rise(rise_a), .fall(fall_a)
    );

    in_filter #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in(in_sat),
`ifdef IN_FILTER_EDGE_CNT_EN
        .cnt_clr(cnt_clr_sat), .edge_cnt(edge_cnt_sat),
`endif
        .out(out_sat), .rise(rise_sat), .fall(fall_sat)
    );

    in_filter #(.FILTER_LEN(1)) dut_f1 (
        .clk(clk), .rst(rst), .in(in_f1),
`ifdef IN_FILTER_EDGE_CNT_EN
        .cnt_clr(1'b0), .edge_cnt(edge_cnt_f1),
`endif
        .out(out_f1), .rise(rise_f1), .fall(fall_f1)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endfunction

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] ev(input logic is_rise, input int at_edge);
        return {is_rise, 31'(at_edge)};
    endfunction

    // Monitor for the default instance: every strobe must match the head of exp_q.
    always @(posedge clk) begin
        logic [31:0] e;
        #1;
        if (!rst && (rise_a || fall_a)) begin
            check("a_rise_fall_exclusive", 32'(rise_a & fall_a), 0);
            if (exp_q.size() == 0) begin
                check("a_unexpected_strobe", 32'({rise_a, fall_a}), 0);
            end else begin
                e = exp_q.pop_front();
                check("a_strobe_kind", 32'(rise_a), 32'(e[31]));
                check("a_strobe_edge", 32'(edge_n), 32'(e[30:0]));
                check("a_out_at_strobe", 32'(out_a), 32'(rise_a));
            end
        end
    end

    always @(posedge clk) begin
        logic [31:0] e;
        #1;
        if (!rst && (rise_f1 || fall_f1)) begin
            if (exp_f1_q.size() == 0) begin
                check("f1_unexpected_strobe", 32'({rise_f1, fall_f1}), 0);
            end else begin
                e = exp_f1_q.pop_front();
                check("f1_strobe_kind", 32'(rise_f1), 32'(e[31]));
                check("f1_strobe_edge", 32'(edge_n), 32'(e[30:0]));
                check("f1_out_at_strobe", 32'(out_f1), 32'(rise_f1));
            end
        end
    end

`ifdef IN_FILTER_EDGE_CNT_EN
    // Counter lags its strobe by one edge.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            sat_pend = 1'b0;
        end else begin
            if (sat_pend) begin
                if (exp_sat_q.size() == 0) begin
                    check("sat_unexpected_event", 32'(edge_cnt_sat), 32'hffff_ffff);
                end else begin
                    check("sat_edge_cnt", 32'(edge_cnt_sat), exp_sat_q.pop_front());
                end
            end
            sat_pend = rise_sat | fall_sat;
        end
    end
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r;
        int k;
        logic [31:0] sat_tbl [0:4];
        sat_tbl[0] = 1; sat_tbl[1] = 2; sat_tbl[2] = 3; sat_tbl[3] = 3; sat_tbl[4] = 3;

        rst = 1'b1; in_a = 1'b1; in_sat = 1'b0; in_f1 = 1'b0;
`ifdef IN_FILTER_EDGE_CNT_EN
        cnt_clr_a = 1'b0; cnt_clr_sat = 1'b0;
`endif
        wait_n(4);
        check("reset_out", 32'(out_a), 0);
        check("reset_rise", 32'(rise_a), 0);
        check("reset_fall", 32'(fall_a), 0);
        check("reset_fc", 32'(dut.r_fc), 0);
`ifdef IN_FILTER_EDGE_CNT_EN
        check("reset_edge_cnt", 32'(edge_cnt_a), 0);
`endif

        // Release with in=1 already held: rise on the 6th edge.
        r = edge_n;
        rst = 1'b0;
        exp_q.push_back(ev(1'b1, r + 6));
        wait_n(5);
        check("release_out_edge5", 32'(out_a), 0);
        wait_n(5);
        check("release_out", 32'(out_a), 1);
`ifdef IN_FILTER_EDGE_CNT_EN
        check("cnt_after_first_rise", 32'(edge_cnt_a), 1);
`endif

        k = edge_n; in_a = 1'b0; exp_q.push_back(ev(1'b0, k + 6));
        wait_n(10);
        check("out_after_fall", 32'(out_a), 0);
`ifdef IN_FILTER_EDGE_CNT_EN
        check("cnt_after_fall", 32'(edge_cnt_a), 2);
        cnt_clr_a = 1'b1; wait_n(1); cnt_clr_a = 1'b0; wait_n(1);
        check("cnt_cleared", 32'(edge_cnt_a), 0);
`endif

        // 3-cycle glitch: fc climbs to 3, never reaches the update, then drops back.
        in_a = 1'b1; wait_n(3); in_a = 1'b0;
        wait_n(2);
        check("glitch_fc_peak", 32'(dut.r_fc), 3);
        check("glitch_out_mid", 32'(out_a), 0);
        wait_n(8);
        check("glitch_fc_back", 32'(dut.r_fc), 0);
        check("glitch_out_end", 32'(out_a), 0);

        k = edge_n; in_a = 1'b1; exp_q.push_back(ev(1'b1, k + 6));
        wait_n(10);
        k = edge_n; in_a = 1'b0; exp_q.push_back(ev(1'b0, k + 6));
        wait_n(10);
        check("steady_out", 32'(out_a), 0);
`ifdef IN_FILTER_EDGE_CNT_EN
        check("steady_edge_cnt", 32'(edge_cnt_a), 2);
`endif

        // Clear in the same cycle as the rise strobe drops that event.
        k = edge_n; in_a = 1'b1; exp_q.push_back(ev(1'b1, k + 6));
        wait_n(6);
`ifdef IN_FILTER_EDGE_CNT_EN
        cnt_clr_a = 1'b1;
`endif
        wait_n(1);
`ifdef IN_FILTER_EDGE_CNT_EN
        cnt_clr_a = 1'b0;
`endif
        wait_n(3);
        check("clr_race_out", 32'(out_a), 1);
`ifdef IN_FILTER_EDGE_CNT_EN
        check("clr_race_edge_cnt", 32'(edge_cnt_a), 0);
`endif

        // FILTER_LEN=1: a one-cycle input pulse gives rise then fall on consecutive edges.
        k = edge_n; in_f1 = 1'b1;
        exp_f1_q.push_back(ev(1'b1, k + 3));
        exp_f1_q.push_back(ev(1'b0, k + 4));
        wait_n(1); in_f1 = 1'b0;
        wait_n(6);
        check("f1_out_end", 32'(out_f1), 0);

        for (int i = 0; i < 5; i++) begin
            in_sat = ~in_sat;
`ifdef IN_FILTER_EDGE_CNT_EN
            exp_sat_q.push_back(sat_tbl[i]);
`endif
            wait_n(10);
        end
        check("sat_out_end", 32'(out_sat), 1);

        // Reset mid-filter, then the full latency is needed again.
        in_a = 1'b0; wait_n(3);
        rst = 1'b1; in_a = 1'b1;
        #1;
        check("midrst_out", 32'(out_a), 0);
        check("midrst_fc", 32'(dut.r_fc), 0);
        check("midrst_fall", 32'(fall_a), 0);
        wait_n(2);
        r = edge_n; rst = 1'b0;
        exp_q.push_back(ev(1'b1, r + 6));
        wait_n(5);
        check("midrst_out_edge5", 32'(out_a), 0);
        wait_n(5);
        check("midrst_out_final", 32'(out_a), 1);

        check("a_events_left", 32'(exp_q.size()), 0);
        check("f1_events_left", 32'(exp_f1_q.size()), 0);
`ifdef IN_FILTER_EDGE_CNT_EN
        check("sat_events_left", 32'(exp_sat_q.size()), 0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/in_filter.md
# in_filter

Input conditioning stage that drives the `in` pin of the registered datapath. It takes an asynchronous level from off-block, synchronizes it into the `clk` domain, and rejects glitches shorter than a programmable number of cycles. It presents a clean registered level plus one-cycle rise/fall strobes. An optional saturating event counter supports debug.

## Interface
Parameters:
- SYNC_STAGES, default 2: synchronizer flop count; legal range is 2 or more.
- FILTER_LEN, default 4: consecutive cycles the synchronized level must differ from `out` before `out` follows; legal range is 1 or more.
- CNT_W, default 8: event counter width; legal range is 1 or more.

Ports:
- clk  input  1: single clock; all flops are rising-edge.
- rst  input  1: asynchronous, active-high reset.
- in  input  1: asynchronous raw level; no timing relation to `clk`.
- cnt_clr  input  1: synchronous clear of `edge_cnt`.
- out  output  1: filtered, registered level.
- rise  output  1: one-cycle strobe, high in the first cycle `out`=1.
- fall  output  1: one-cycle strobe, high in the first cycle `out`=0.
- edge_cnt  output  CNT_W: saturating count of rise+fall events. This port exists only with the macro defined.

## Operation
- Synchronizer:
  - A chain of SYNC_STAGES flops; `s` is the last stage.
  - Every stage resets to 0.
  - No logic sits between stages.
- Filter counter `fc`:
  - Width is max(1, $clog2(FILTER_LEN)); resets to 0.
  - When `s`==`out`: `fc`<=0.
  - When `s`!=`out` and `fc`==FILTER_LEN-1: `out`<=`s` and `fc`<=0.
  - When `s`!=`out` otherwise: `fc`<=`fc`+1.
  - With FILTER_LEN=1, `out` follows `s` on the next edge.
- A glitch on `s` shorter than FILTER_LEN cycles leaves `out` unchanged and returns `fc` to 0.
- `rise` and `fall` are registered alongside `out`:
  - `rise`<=next_out & ~out.
  - `fall`<=~next_out & out.
  - They are never both high.
  - Each is high for exactly one cycle per transition.
- Event counter:
  - Increments on each `rise` or `fall` assertion.
  - Holds at all-ones (no wrap).
  - When `cnt_clr` is high, `edge_cnt`<=0 and clear wins over a same-cycle event (that event is dropped).
- Reset values: `out`=0, `rise`=0, `fall`=0, `edge_cnt`=0, `fc`=0, all sync stages 0.
- Reset mid-filter:
  - Assertion immediately zeroes all state.
  - After deassertion, a steady `in`=1 needs the full SYNC_STAGES+FILTER_LEN cycles before `out` rises.
  - No strobe is generated by reset itself.

## Timing
- Latency:
  - `in` changes, meeting setup before edge E0.
  - `out` changes on edge E0+SYNC_STAGES+FILTER_LEN-1, which is the (SYNC_STAGES+FILTER_LEN)th edge.
  - Defaults give 6 edges.
- `rise`/`fall` go high on the same edge `out` changes and drop on the following edge.
- `edge_cnt` updates one edge after the strobe is visible.
- Only the first sync stage may go metastable.
- `out`, `rise`, `fall` and `edge_cnt` are direct flop outputs with no combinational path from inputs.

## Configuration
- IN_FILTER_EDGE_CNT_EN defined:
  - The event counter and the `cnt_clr`/`edge_cnt` ports are present.
- IN_FILTER_EDGE_CNT_EN undefined:
  - No counter logic is built.
  - `cnt_clr` and `edge_cnt` are absent from the port list.
  - All other behaviour is cycle-identical.

## Structure
- Package `in_filter_pkg` holds:
  - Default constants IN_FILTER_SYNC_STAGES=2, IN_FILTER_LEN=4, IN_FILTER_CNT_W=8.
  - The filter-counter width function.
- Sub-module `sync_chain`:
  - Parameter SYNC_STAGES; ports clk, rst, d, q.
  - Instantiated once.
  - Gives STA a single point at which to mark the async input path as false.

## Test plan
- Reset with `in`=1 held: all outputs 0 during reset. After release, `out` rises on edge 6 with `rise`=1 for exactly that cycle.
- Glitch `in` 0→1 for 3 cycles then back to 0 (defaults): `out`, `rise` and `fall` stay 0 throughout, and `fc` returns to 0.
- Steady 1 then 0, each held 10 cycles: one `rise` and one `fall` pulse, each delayed 6 edges from its input change. `edge_cnt`=2.
- CNT_W=2 with 5 transitions: `edge_cnt` reads 1, 2, 3, 3, 3 (saturation holds at all-ones).
- `cnt_clr` asserted on the same edge a `rise` would increment the counter: `edge_cnt`=0 afterwards.
- FILTER_LEN=1 with a 1-cycle pulse on `s`: `out` pulses for one cycle, and `rise` then `fall` occur on consecutive edges.
